// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-control encodings: occupancy states used by pipe_skid_reg
// and any other valid/ready control block in the datapath.
package pipe_skid_reg_pkg;

    localparam int STATE_W = 2;

    // State value doubles as the number of stored entries.
    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload slot register: loads only on enable, cleared synchronously to RESET_VAL
// by either reset or clear, so stalled bits never toggle.
module pipe_data_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = RESET_VAL;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register (main + skid slot) with synchronous flush.
// in_ready depends only on stored state and flush, never on out_ready.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    state_e           state_q;
    state_e           state_d;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             skid_en;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_ready  = (state_q != ST_TWO) & ~flush;
    assign out_valid = (state_q != ST_EMPTY) & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_q;
    assign count     = state_q;

    // Both fires are already masked by flush, so flush only needs to force the state.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    main_en = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_d = ST_TWO;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d        = ST_ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        main_d = in_data;
        if (main_from_skid) begin
            main_d = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, flush-cycle masking sequence,
// then randomized traffic against a queue reference model.
module tb_pipe_skid_reg;

    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] RST_VAL = '0;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    int n_tests;
    int n_fail;

    pipe_skid_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RST_VAL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             rst;
        logic             fl;
        logic             iv;
        logic [WIDTH-1:0] id;
        logic             ordy;
        logic             e_irdy;
        logic             e_ovld;
        logic [WIDTH-1:0] e_data;
        logic [1:0]       e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic add(input string nm, input logic r, input logic f, input logic iv,
                       input logic [WIDTH-1:0] id, input logic ordy, input logic e_irdy,
                       input logic e_ovld, input logic [WIDTH-1:0] e_data, input logic [1:0] e_cnt);
        vec_t v;
        v.name = nm; v.rst = r; v.fl = f; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_data = e_data; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    logic [WIDTH-1:0] mq[$];
    logic             m_irdy;
    logic             m_ovld;
    logic             irdy_before;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        in_data = '0;
        idle_inputs();

        // Each row drives inputs for one edge; outputs are checked after the edge with
        // all control inputs dropped, so they reflect stored state only.
        //   name          rst fl iv data   ordy | irdy ovld data   cnt
        add("reset1",      1, 0, 1, 'hAA,  0,     1,   0,   'h0,   0);
        add("reset2",      1, 0, 1, 'hAA,  0,     1,   0,   'h0,   0);
        add("stream1",     0, 0, 1, 'h1,   1,     1,   1,   'h1,   1);
        add("stream2",     0, 0, 1, 'h2,   1,     1,   1,   'h2,   1);
        add("stream3",     0, 0, 1, 'h3,   1,     1,   1,   'h3,   1);
        add("stream_end",  0, 0, 0, 'h0,   1,     1,   0,   'h3,   0);
        add("bp_push10",   0, 0, 1, 'h10,  0,     1,   1,   'h10,  1);
        add("bp_hold_one", 0, 0, 0, 'h77,  0,     1,   1,   'h10,  1);
        add("bp_push11",   0, 0, 1, 'h11,  0,     0,   1,   'h10,  2);
        add("bp_push12",   0, 0, 1, 'h12,  0,     0,   1,   'h10,  2);
        add("bp_drain10",  0, 0, 1, 'h12,  1,     1,   1,   'h11,  1);
        add("bp_drain11",  0, 0, 1, 'h12,  1,     1,   1,   'h12,  1);
        add("bp_drain12",  0, 0, 0, 'h0,   1,     1,   0,   'h12,  0);
        add("fl_push20",   0, 0, 1, 'h20,  0,     1,   1,   'h20,  1);
        add("fl_push21",   0, 0, 1, 'h21,  0,     0,   1,   'h20,  2);
        add("fl_two",      0, 1, 1, 'h22,  1,     1,   0,   'h0,   0);
        add("fl_idle",     0, 0, 0, 'h0,   1,     1,   0,   'h0,   0);
        add("rs_push30",   0, 0, 1, 'h30,  0,     1,   1,   'h30,  1);
        add("rs_midfire",  1, 0, 1, 'h31,  1,     1,   0,   'h0,   0);
        add("rs_push40",   0, 0, 1, 'h40,  0,     1,   1,   'h40,  1);
        add("rs_push41",   0, 0, 1, 'h41,  0,     0,   1,   'h40,  2);
        add("rs_two_fl",   1, 1, 1, 'h42,  1,     1,   0,   'h0,   0);
        add("fl_one_push", 0, 0, 1, 'h50,  0,     1,   1,   'h50,  1);
        add("fl_one",      0, 1, 0, 'h0,   0,     1,   0,   'h0,   0);

        @(negedge clk);
        foreach (vecs[i]) begin
            reset     = vecs[i].rst;
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            idle_inputs();
            #1;
            check({vecs[i].name, ".in_ready"},  {{(WIDTH-1){1'b0}}, in_ready},  {{(WIDTH-1){1'b0}}, vecs[i].e_irdy});
            check({vecs[i].name, ".out_valid"}, {{(WIDTH-1){1'b0}}, out_valid}, {{(WIDTH-1){1'b0}}, vecs[i].e_ovld});
            check({vecs[i].name, ".out_data"},  out_data, vecs[i].e_data);
            check({vecs[i].name, ".count"},     {{(WIDTH-2){1'b0}}, count},     {{(WIDTH-2){1'b0}}, vecs[i].e_cnt});
        end

        // Flush masks both handshakes combinationally within its own cycle.
        @(negedge clk);
        in_valid = 1'b1; in_data = 'h60; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 'h61;
        @(posedge clk); #1;
        flush = 1'b1; out_ready = 1'b1; in_data = 'h62;
        #1;
        check("flush_masks_in_ready",  {{(WIDTH-1){1'b0}}, in_ready},  '0);
        check("flush_masks_out_valid", {{(WIDTH-1){1'b0}}, out_valid}, '0);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check("flush_after_count", {{(WIDTH-2){1'b0}}, count}, '0);
        check("flush_after_data",  out_data, RST_VAL);

        // Randomized traffic against a FIFO model of depth two.
        mq.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data   = $urandom;
            #1;
            m_irdy = (mq.size() < 2) && !flush;
            m_ovld = (mq.size() > 0) && !flush;
            check("rnd.in_ready",  {{(WIDTH-1){1'b0}}, in_ready},  {{(WIDTH-1){1'b0}}, m_irdy});
            check("rnd.out_valid", {{(WIDTH-1){1'b0}}, out_valid}, {{(WIDTH-1){1'b0}}, m_ovld});
            check("rnd.count",     {{(WIDTH-2){1'b0}}, count},     mq.size());
            if (mq.size() > 0) begin
                check("rnd.out_data", out_data, mq[0]);
            end
            irdy_before = in_ready;
            out_ready = ~out_ready;
            #1;
            check("rnd.in_ready_vs_out_ready", {{(WIDTH-1){1'b0}}, in_ready}, {{(WIDTH-1){1'b0}}, irdy_before});
            out_ready = ~out_ready;
            #1;
            @(posedge clk);
            if (reset || flush) begin
                mq.delete();
            end else begin
                if (m_ovld && out_ready) begin
                    void'(mq.pop_front());
                end
                if (m_irdy && in_valid) begin
                    mq.push_back(in_data);
                end
            end
            #1;
            if ((reset || flush) && (cyc % 4 == 0)) begin
                idle_inputs();
                #1;
                check("rnd.cleared_data", out_data, RST_VAL);
            end
        end

        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
